// File: rtl/date_year_display.sv
// Purpose: captures alternating date/year BCD frames, checks them and multiplexes them onto a 4-digit 7-segment display.
// Latency: frame-to-register 1 cycle; seg/dp/an are registered, 1 cycle after digit index or register change.
// Backpressure: none; a frame is sampled every cycle, and illegal or out-of-order frames only raise sticky flags.
module date_year_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int PAGE_SCANS  = 500
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       date_year,
   input  logic [3:0] num3,
   input  logic [3:0] num2,
   input  logic [3:0] num1,
   input  logic [3:0] num0,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       date_valid,
   output logic       year_valid,
   output logic       bcd_err,
   output logic       seq_err
);

   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int SW = (PAGE_SCANS > 1) ? $clog2(PAGE_SCANS) : 1;
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST    = SW'(PAGE_SCANS - 1);

   typedef enum logic {
      SHOW_DATE = 1'b0,
      SHOW_YEAR = 1'b1
   } page_t;

   logic [15:0]   date_reg;
   logic [15:0]   year_reg;
   logic          prev_seen;
   logic          prev_type;
   logic          frame_legal;

   logic [RW-1:0] refresh_cnt;
   logic [SW-1:0] scan_cnt;
   logic [1:0]    digit_idx;
   page_t         page;

   logic [15:0]   page_digits;
   logic          page_valid;
   logic [3:0]    cur_digit;
   logic [3:0]    cur_anode;

   // Active-low segment pattern {g,f,e,d,c,b,a}; anything that is not a decimal digit is blank.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign frame_legal = (num3 <= 4'd9) && (num2 <= 4'd9) && (num1 <= 4'd9) && (num0 <= 4'd9);

   // Frame capture, legality flag and date/year alternation check.
   always_ff @(posedge clock) begin
      if (reset) begin
         date_reg   <= 16'h0000;
         year_reg   <= 16'h0000;
         date_valid <= 1'b0;
         year_valid <= 1'b0;
         bcd_err    <= 1'b0;
         seq_err    <= 1'b0;
         prev_seen  <= 1'b0;
         prev_type  <= 1'b0;
      end else begin
         if (frame_legal) begin
            if (date_year) begin
               year_reg   <= {num3, num2, num1, num0};
               year_valid <= 1'b1;
            end else begin
               date_reg   <= {num3, num2, num1, num0};
               date_valid <= 1'b1;
            end
         end else begin
            bcd_err <= 1'b1;
         end
         // Illegal frames still take part in the alternation check.
         if (prev_seen && (date_year == prev_type)) begin
            seq_err <= 1'b1;
         end
         prev_seen <= 1'b1;
         prev_type <= date_year;
      end
   end

   // Select the digit of the page currently on show and its anode pattern.
   always_comb begin
      page_digits = (page == SHOW_DATE) ? date_reg : year_reg;
      page_valid  = (page == SHOW_DATE) ? date_valid : year_valid;
      cur_digit   = 4'h0;
      cur_anode   = 4'b1111;
      case (digit_idx)
         2'd3: begin cur_digit = page_digits[15:12]; cur_anode = 4'b0111; end
         2'd2: begin cur_digit = page_digits[11:8];  cur_anode = 4'b1011; end
         2'd1: begin cur_digit = page_digits[7:4];   cur_anode = 4'b1101; end
         default: begin cur_digit = page_digits[3:0]; cur_anode = 4'b1110; end
      endcase
   end

   // Refresh timer, digit scan and page FSM, with registered display outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         refresh_cnt <= '0;
         scan_cnt    <= '0;
         digit_idx   <= 2'd3;
         page        <= SHOW_DATE;
         seg         <= 7'h7F;
         dp          <= 1'b1;
         an          <= 4'b0111;
      end else begin
         // Outputs follow the pre-edge state, so a same-cycle capture appears one cycle later.
         seg <= page_valid ? bcd_to_seg(cur_digit) : 7'h7F;
         dp  <= !((page == SHOW_DATE) && (digit_idx == 2'd2) && date_valid);
         an  <= cur_anode;

         if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            if (digit_idx == 2'd0) begin
               digit_idx <= 2'd3;
               if (scan_cnt == SCAN_LAST) begin
                  scan_cnt <= '0;
                  page     <= (page == SHOW_DATE) ? SHOW_YEAR : SHOW_DATE;
               end else begin
                  scan_cnt <= scan_cnt + 1'b1;
               end
            end else begin
               digit_idx <= digit_idx - 2'd1;
            end
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_date_year_display.sv
// Purpose: directed self-checking bench for date_year_display with a fast refresh and one scan per page.
// Latency: every check samples 1 time unit after the rising edge that produced the value.
// Backpressure: not applicable; one frame is driven per clock.
module tb_date_year_display;

   logic       clock;
   logic       reset;
   logic       date_year;
   logic [3:0] num3, num2, num1, num0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       date_valid, year_valid, bcd_err, seq_err;

   int n_checks = 0;
   int n_errors = 0;

   date_year_display #(
      .REFRESH_DIV (2),
      .PAGE_SCANS  (1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .date_year  (date_year),
      .num3       (num3),
      .num2       (num2),
      .num1       (num1),
      .num0       (num0),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .date_valid (date_valid),
      .year_valid (year_valid),
      .bcd_err    (bcd_err),
      .seq_err    (seq_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Drive one frame and advance to just after the edge that samples it.
   task automatic frame(input logic dy, input logic [15:0] d);
      date_year = dy;
      {num3, num2, num1, num0} = d;
      @(posedge clock);
      #1;
   endtask

   // Expected {an, seg, dp} after edge k of the first run (k counted from reset release).
   // Each digit is held two cycles; pages alternate every 8 cycles starting with the date page.
   function automatic logic [11:0] exp_disp(input int k);
      int         p;
      int         idx;
      logic       is_date;
      logic [15:0] d;
      logic [3:0] dig;
      logic [6:0] s;
      logic [3:0] a;
      p       = (k - 1) % 16;
      is_date = (p < 8);
      idx     = 3 - (p % 8) / 2;
      d       = is_date ? ((k >= 34) ? 16'h5678 : 16'h1114) : 16'h2000;
      dig     = d[idx*4 +: 4];
      case (dig)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         default: s = 7'h7F;
      endcase
      if (k == 1) s = 7'h7F;   // nothing captured yet when the first slot is registered
      a      = 4'b1111;
      a[idx] = 1'b0;
      return {a, s, (is_date && idx == 2) ? 1'b0 : 1'b1};
   endfunction

   // Expected {an, seg, dp} with nothing valid: anodes scan, display blank, dp off.
   function automatic logic [11:0] exp_blank(input int j);
      int         idx;
      logic [3:0] a;
      idx    = 3 - (((j - 1) % 16) % 8) / 2;
      a      = 4'b1111;
      a[idx] = 1'b0;
      return {a, 7'h7F, 1'b1};
   endfunction

   initial begin
      logic        dy;
      logic [15:0] d;

      clock     = 1'b0;
      reset     = 1'b1;
      date_year = 1'b0;
      {num3, num2, num1, num0} = 16'h0000;
      repeat (2) @(posedge clock);
      #1;
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_an", 32'(an), 32'h7);
      check("rst_flags", 32'({date_valid, year_valid, bcd_err, seq_err}), 32'h0);
      reset = 1'b0;

      // Alternating date/year frames; an illegal date frame at 17, a new date value from 33.
      for (int k = 1; k <= 40; k++) begin
         dy = (k % 2 == 0);
         if (dy)            d = 16'h2000;
         else if (k == 17)  d = 16'h99A9;
         else if (k >= 33)  d = 16'h5678;
         else               d = 16'h1114;
         frame(dy, d);
         check($sformatf("disp_c%0d", k), 32'({an, seg, dp}), 32'(exp_disp(k)));
         if (k == 1) check("valid_c1", 32'({date_valid, year_valid}), 32'h2);
         if (k == 2) check("valid_c2", 32'({date_valid, year_valid}), 32'h3);
         if (k == 16) check("bcd_before", 32'(bcd_err), 32'h0);
         if (k == 17) check("bcd_after", 32'(bcd_err), 32'h1);
         if (k == 40) check("bcd_sticky", 32'(bcd_err), 32'h1);
         if (k == 40) check("seq_clean", 32'(seq_err), 32'h0);
      end

      // Two consecutive date frames raise seq_err, which then survives legal frames.
      frame(1'b0, 16'h1114);
      check("seq_c41", 32'(seq_err), 32'h0);
      frame(1'b0, 16'h1114);
      check("seq_c42", 32'(seq_err), 32'h1);
      frame(1'b1, 16'h2000);
      frame(1'b0, 16'h1114);
      check("seq_hold", 32'(seq_err), 32'h1);

      // Scan now sits on the year page, digit 1; reset there, with a legal frame present.
      reset = 1'b1;
      frame(1'b0, 16'h3333);
      check("mid_rst_an", 32'(an), 32'h7);
      check("mid_rst_seg", 32'(seg), 32'h7F);
      check("mid_rst_dp", 32'(dp), 32'h1);
      check("mid_rst_flags", 32'({date_valid, year_valid, bcd_err, seq_err}), 32'h0);
      reset = 1'b0;

      // Only illegal frames after reset: both pages blank while anodes keep scanning.
      for (int j = 1; j <= 16; j++) begin
         frame((j % 2 == 0), 16'hFFFF);
         check($sformatf("blank_c%0d", j), 32'({an, seg, dp}), 32'(exp_blank(j)));
      end
      check("blank_valid", 32'({date_valid, year_valid}), 32'h0);
      check("blank_seq", 32'(seq_err), 32'h0);
      check("blank_bcd", 32'(bcd_err), 32'h1);

      // Last frame was a year frame; another illegal year frame still trips the alternation check.
      frame(1'b1, 16'hFFFF);
      check("seq_illegal", 32'(seq_err), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/date_year_display.md
DATE_YEAR_DISPLAY -- requirements
Module: date_year_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (min 2).
REQ-002 Parameter PAGE_SCANS, default 500, full 4-digit scans per displayed page (min 1).
REQ-003 Port clock  input  1  single system clock; all state updates on posedge clock.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 Port date_year  input  1  frame type of the incoming stream: 0 = date frame, 1 = year frame.
REQ-006 Ports num3, num2, num1, num0  input  4 each  BCD digits of the current frame; num3 is the most significant digit.
REQ-007 Port seg  output  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-008 Port dp  output  1  active-low decimal point.
REQ-009 Port an  output  4  active-low anodes; an[3] selects the leftmost digit.
REQ-010 Port date_valid, year_valid  output  1 each  a legal frame of that type has been captured.
REQ-011 Port bcd_err  output  1  sticky flag: a frame contained a digit greater than 9.
REQ-012 Port seq_err  output  1  sticky flag: two consecutive frames carried the same date_year value.

Function
REQ-013 Capture: every cycle the block samples {date_year, num3..num0}; if all four digits are <=9, the frame is stored in date_reg (date_year=0) or year_reg (date_year=1) and the matching *_valid is set on the next edge.
REQ-014 Illegal frame (any digit >9): neither register changes, and bcd_err is set on the next edge and held until reset.
REQ-015 Alternation check: prev_type holds the last sampled date_year; seq_err is set when a sampled date_year equals prev_type, except on the first sample after reset; seq_err holds until reset.
REQ-016 Illegal frames still update prev_type and are included in the alternation check.
REQ-017 Refresh counter: counts 0..REFRESH_DIV-1 and wraps; at the wrap, digit index advances 3->2->1->0->3.
REQ-018 Page FSM: states SHOW_DATE and SHOW_YEAR; it toggles once PAGE_SCANS full scans complete, i.e. when the digit index wraps from 0 to 3 and the scan count equals PAGE_SCANS-1; the scan count then clears.
REQ-019 Exactly one an bit is low at a time, matching the digit index; seg shows the selected digit of the page register, decoded from BCD.
REQ-020 If the current page's *_valid is 0, all seg bits are 1 (blank); the anodes keep scanning.
REQ-021 dp = 0 only in SHOW_DATE, only when the digit index is 2, and only when date_valid = 1; otherwise dp = 1.
REQ-022 Outputs seg, dp and an are registered: display latency is 1 cycle from the digit index or register change.
REQ-023 When a capture and a display read of the same register occur in the same cycle, the display shows the old value in that cycle and the new value from the next cycle.

Reset
REQ-024 While reset=1, capture is suppressed and no frame is stored.
REQ-025 One clock edge with reset=1 sets:
- date_reg = year_reg = 0
- date_valid = year_valid = 0
- bcd_err = seq_err = 0
- prev_type marked "none"
- refresh counter, scan count = 0
- digit index = 3, page = SHOW_DATE
- seg = 7'h7F, dp = 1, an = 4'b0111
REQ-026 Reset asserted mid-page or mid-slot aborts the page/slot; after release, scanning restarts at digit 3 of SHOW_DATE.

Verification
REQ-027 REFRESH_DIV=2, PAGE_SCANS=1. Stimulus: alternating frames date=1,1,1,4 then year=2,0,0,0. Required:
- date_valid = year_valid = 1 after 2 cycles
- SHOW_DATE an sequence 0111,1011,1101,1110, seg = 1,1,1,4 (7'h79,7'h79,7'h79,7'h19)
- dp low only on digit 2
- page then flips to SHOW_YEAR, seg = 2,0,0,0 (7'h24,7'h40,7'h40,7'h40)
REQ-028 Frame date_year=0, num1=4'hA. Required: bcd_err = 1 next cycle; date_reg unchanged; date page still shows the previous value.
REQ-029 Two consecutive date_year=0 frames. Required: seq_err = 1 and stays 1 through legal frames until reset.
REQ-030 No frames after reset. Required: seg = 7'h7F and dp = 1 on both pages; an still scans.
REQ-031 Reset asserted during SHOW_YEAR digit 1. Required: next cycle an = 0111, all flags 0, page = SHOW_DATE, blank display.
REQ-032 Frame capture in the same cycle as that digit is displayed. Required: old value shown in that cycle, new value from the next cycle.
